// File: rtl/regfile_pkg.sv
// Shared register-file widths and requester identifiers for the write-back arbiter.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: a lone request wins outright, a tie goes to
// the pointer, and the pointer then moves to whichever side lost.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_gnt_a,
  output logic o_gnt_b
);
  req_id_t r_ptr;

  // Grants are forced low while reset is held so nothing transfers during reset.
  assign o_gnt_a = !reset && i_req_a && (!i_req_b || (r_ptr == REQ_A));
  assign o_gnt_b = !reset && i_req_b && (!i_req_a || (r_ptr == REQ_B));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= REQ_A;
    end else if (o_gnt_a) begin
      r_ptr <= REQ_B;
    end else if (o_gnt_b) begin
      r_ptr <= REQ_A;
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: merges ALU and memory write requests into one
// write port. Define REGFILE_WB_ARB_BYPASS_EN to forward the pending write to the read ports.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [REG_DATA_W-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [REG_DATA_W-1:0] b_data,
  output logic                  b_ready,
  output logic                  rf_wrenable,
  output logic [REG_ADDR_W-1:0] rf_addr,
  output logic [REG_DATA_W-1:0] rf_data,
  output logic [CNT_W-1:0]      a_grant_cnt,
  output logic [CNT_W-1:0]      b_grant_cnt,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  input  logic [REG_ADDR_W-1:0] rd_addr2,
  input  logic [REG_DATA_W-1:0] rf_rdata1,
  input  logic [REG_DATA_W-1:0] rf_rdata2,
  output logic [REG_DATA_W-1:0] rd_data1,
  output logic [REG_DATA_W-1:0] rd_data2
);
  logic                  w_xfer;
  logic                  w_do_write;
  logic [REG_ADDR_W-1:0] w_xfer_addr;
  logic [REG_DATA_W-1:0] w_xfer_data;
  logic                  r_wren;
  logic [REG_ADDR_W-1:0] r_addr;
  logic [REG_DATA_W-1:0] r_data;
  logic [CNT_W-1:0]      r_a_cnt;
  logic [CNT_W-1:0]      r_b_cnt;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .i_req_a (a_valid),
    .i_req_b (b_valid),
    .o_gnt_a (a_ready),
    .o_gnt_b (b_ready)
  );

  assign w_xfer      = a_ready || b_ready;
  assign w_xfer_addr = a_ready ? a_addr : b_addr;
  assign w_xfer_data = a_ready ? a_data : b_data;
  // Register 0 is hardwired to zero: accept and count, but never write it.
  assign w_do_write  = w_xfer && (w_xfer_addr != REG_ZERO);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wren  <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_a_cnt <= '0;
      r_b_cnt <= '0;
    end else begin
      r_wren <= w_do_write;
      if (w_do_write) begin
        r_addr <= w_xfer_addr;
        r_data <= w_xfer_data;
      end
      if (a_ready) r_a_cnt <= r_a_cnt + CNT_W'(1);
      if (b_ready) r_b_cnt <= r_b_cnt + CNT_W'(1);
    end
  end

  // Masking with reset kills a write left over from the cycle before reset rose.
  assign rf_wrenable = r_wren && !reset;
  assign rf_addr     = r_addr;
  assign rf_data     = r_data;
  assign a_grant_cnt = r_a_cnt;
  assign b_grant_cnt = r_b_cnt;

  logic [REG_ADDR_W-1:0] w_rd_addr  [2];
  logic [REG_DATA_W-1:0] w_rf_rdata [2];
  logic [REG_DATA_W-1:0] w_rd_data  [2];

  assign w_rd_addr[0]  = rd_addr1;
  assign w_rd_addr[1]  = rd_addr2;
  assign w_rf_rdata[0] = rf_rdata1;
  assign w_rf_rdata[1] = rf_rdata2;
  assign rd_data1      = w_rd_data[0];
  assign rd_data2      = w_rd_data[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd_port
`ifdef REGFILE_WB_ARB_BYPASS_EN
      assign w_rd_data[gi] = (rf_wrenable && (rf_addr == w_rd_addr[gi])) ? rf_data
                                                                         : w_rf_rdata[gi];
`else
      assign w_rd_data[gi] = w_rf_rdata[gi];
`endif
    end
  endgenerate

`ifndef REGFILE_WB_ARB_BYPASS_EN
  logic w_unused_rd_addr;
  assign w_unused_rd_addr = ^{w_rd_addr[0], w_rd_addr[1]};
`endif
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset (clk rising edge; reset sampled only on clk).
REQ-002 Parameter: CNT_W, 16, width of each per-requester grant counter.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 a_valid / b_valid  input  1 each  write request from requester A (ALU) / B (memory).
REQ-006 a_addr / b_addr  input  5 each  destination register number.
REQ-007 a_data / b_data  input  32 each  write data.
REQ-008 a_ready / b_ready  output  1 each  request accepted this cycle.
REQ-009 rf_wrenable  output  1  register-file write enable.
REQ-010 rf_addr / rf_data  output  5 / 32  register-file write address / data.
REQ-011 a_grant_cnt / b_grant_cnt  output  CNT_W each  accepted-request counters.
REQ-012 rd_addr1 / rd_addr2  input  5 each  read-port addresses (used only with REQ-028).
REQ-013 rf_rdata1 / rf_rdata2  input  32 each  raw register-file read data.
REQ-014 rd_data1 / rd_data2  output  32 each  read data delivered to the datapath.

Function
REQ-015 Transfer SHALL occur on a requester when valid && ready in the same cycle; at most one transfer per cycle.
REQ-016 ready SHALL be combinational from valid and the priority pointer; ready SHALL never be high while its valid is low.
REQ-017 Single valid: that requester SHALL be granted immediately, regardless of pointer.
REQ-018 Both valid: the requester named by the 1-bit round-robin pointer SHALL be granted; the other's ready SHALL be low and it SHALL hold valid/addr/data stable until accepted.
REQ-019 After any grant the pointer SHALL point to the non-granted requester; with no grant the pointer SHALL hold.
REQ-020 Latency: a transfer in cycle N SHALL drive rf_wrenable=1, rf_addr, rf_data in cycle N+1 for exactly one cycle; no transfer in N gives rf_wrenable=0 in N+1.
REQ-021 A transfer with addr==0 SHALL be accepted and counted but SHALL NOT assert rf_wrenable in N+1 (register 0 is constant zero).
REQ-022 rf_addr/rf_data SHALL hold their last values when rf_wrenable=0.
REQ-023 Each grant counter SHALL increment by 1 per transfer of its requester and wrap from 2^CNT_W-1 to 0.
REQ-024 Without REQ-028, rd_data1/rd_data2 SHALL equal rf_rdata1/rf_rdata2.

Reset
REQ-025 During reset a_ready=b_ready=0 and no transfer SHALL occur.
REQ-026 Reset SHALL set rf_wrenable=0, rf_addr=0, rf_data=0, pointer=A, both counters=0; reset asserted in cycle N SHALL suppress any write pending from cycle N-1's transfer.

Configuration
REQ-027 Macro REGFILE_WB_ARB_BYPASS_EN SHALL select write-to-read forwarding.
REQ-028 Defined: rd_dataK SHALL equal rf_data when rf_wrenable=1 and rf_addr==rd_addrK, else rf_rdataK (combinational, per port).
REQ-029 Undefined: no forwarding logic; REQ-024 applies; ports remain present.

Structure
REQ-030 Package regfile_pkg SHALL hold REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'd0 and the requester-id enum (REQ_A, REQ_B).
REQ-031 Arbitration SHALL be one sub-module rr_arb2 (2 requests, pointer state, 2 grants); write stage and counters stay in the top.

Verification
REQ-032 Reset then a_valid=1, a_addr=5, a_data=0xDEADBEEF one cycle -> a_ready=1; next cycle rf_wrenable=1, rf_addr=5, rf_data=0xDEADBEEF; a_grant_cnt=1.
REQ-033 Both valid for 4 cycles (A addr 3, B addr 4) -> grants A,B,A,B; rf_addr 3,4,3,4 one cycle later; counters 2/2.
REQ-034 b_valid=1, b_addr=0, b_data=0x12345678 -> b_ready=1, b_grant_cnt=1, rf_wrenable stays 0.
REQ-035 CNT_W=4, 16 A transfers -> a_grant_cnt returns to 0.
REQ-036 With REGFILE_WB_ARB_BYPASS_EN: write addr 7 data 0xA5A5A5A5, rd_addr1=7, rf_rdata1=0 during write cycle -> rd_data1=0xA5A5A5A5; without macro -> 0.
REQ-037 Transfer in cycle N, reset in N+1 -> rf_wrenable=0 in N+1, pointer=A, counters 0.
